// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder. It takes completed receiver frames into the CLK domain
// and produces key events and held flags for the left, right and fire game controls.
module ps2_scancode_decoder #(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] KEY_LEFT_CODE  = 8'h6B,
  parameter bit         KEY_LEFT_EXT   = 1'b1,
  parameter logic [7:0] KEY_RIGHT_CODE = 8'h74,
  parameter bit         KEY_RIGHT_EXT  = 1'b1,
  parameter logic [7:0] KEY_FIRE_CODE  = 8'h29,
  parameter bit         KEY_FIRE_EXT   = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Interrupt,
  input  logic [7:0] ReadVal,
  input  logic       ParityBit,
  output logic       KeyValid,
  output logic [7:0] KeyCode,
  output logic       KeyExtended,
  output logic       KeyRelease,
  output logic       KeyLeft,
  output logic       KeyRight,
  output logic       KeyFire,
  output logic       ParityError
);

  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0]   HELD_CODES   = {KEY_FIRE_CODE, KEY_RIGHT_CODE, KEY_LEFT_CODE};
  localparam logic [2:0]    HELD_EXTS    = {KEY_FIRE_EXT, KEY_RIGHT_EXT, KEY_LEFT_EXT};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXT    = 3'd1,
    BRK    = 3'd2,
    EXTBRK = 3'd3,
    SKIP   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [2:0]           skip_reg, skip_next;
  logic [TW-1:0]        timeout_reg, timeout_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                 int_prev_reg;
  logic                 strobe;
  logic                 parity_ok;

  logic                 ev_valid;
  logic                 ev_ext;
  logic                 ev_rel;
  logic                 held_clear;
  logic                 parity_err;

  logic                 key_valid_reg;
  logic [7:0]           key_code_reg;
  logic                 key_ext_reg;
  logic                 key_rel_reg;
  logic                 parity_err_reg;
  logic [2:0]           held_reg, held_next;

  // Flops preset to 1 so a frame already high across reset never produces an edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync_reg     <= '1;
      int_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], Interrupt};
      int_prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign strobe    = sync_reg[SYNC_STAGES-1] & ~int_prev_reg;
  assign parity_ok = ^{ReadVal, ParityBit};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg   <= IDLE;
      skip_reg    <= 3'd0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      skip_reg    <= skip_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    skip_next    = skip_reg;
    timeout_next = timeout_reg;
    if (strobe) begin
      timeout_next = '0;
      if (!parity_ok) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            case (ReadVal)
              8'hE0:   state_next = EXT;
              8'hF0:   state_next = BRK;
              8'hE1: begin
                state_next = SKIP;
                skip_next  = 3'd7;
              end
              default: state_next = IDLE;
            endcase
          end
          EXT: begin
            case (ReadVal)
              8'hF0:   state_next = EXTBRK;
              8'hE0:   state_next = EXT;
              default: state_next = IDLE;
            endcase
          end
          BRK:    state_next = IDLE;
          EXTBRK: state_next = IDLE;
          SKIP: begin
            skip_next = (skip_reg == 3'd0) ? 3'd0 : skip_reg - 3'd1;
            if (skip_reg <= 3'd1) state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (state_reg != IDLE) begin
      // A half-received prefix sequence is abandoned after a long silence.
      if (timeout_reg == TIMEOUT_LAST) begin
        state_next   = IDLE;
        timeout_next = '0;
      end else begin
        timeout_next = timeout_reg + 1'b1;
      end
    end else begin
      timeout_next = '0;
    end
  end

  always_comb begin
    ev_valid   = 1'b0;
    ev_ext     = 1'b0;
    ev_rel     = 1'b0;
    held_clear = 1'b0;
    parity_err = strobe & ~parity_ok;
    if (strobe && parity_ok) begin
      case (state_reg)
        IDLE: begin
          case (ReadVal)
            8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hFE, 8'hEE: ev_valid = 1'b0;
            8'h00, 8'hFF, 8'hAA:                      held_clear = 1'b1;
            default:                                  ev_valid = 1'b1;
          endcase
        end
        EXT: begin
          if (ReadVal != 8'hF0 && ReadVal != 8'hE0 && ReadVal != 8'h12) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        BRK: begin
          ev_valid = 1'b1;
          ev_rel   = 1'b1;
        end
        EXTBRK: begin
          if (ReadVal != 8'h12) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            ev_rel   = 1'b1;
          end
        end
        default: ev_valid = 1'b0;
      endcase
    end
  end

  // One held flag per game control; a make sets it, the matching break clears it.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_held
      always_comb begin
        held_next[gi] = held_reg[gi];
        if (held_clear) begin
          held_next[gi] = 1'b0;
        end else if (ev_valid && ReadVal == HELD_CODES[gi*8 +: 8] && ev_ext == HELD_EXTS[gi]) begin
          held_next[gi] = ~ev_rel;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (Reset) begin
      key_valid_reg  <= 1'b0;
      key_code_reg   <= 8'h00;
      key_ext_reg    <= 1'b0;
      key_rel_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      held_reg       <= 3'b000;
    end else begin
      key_valid_reg  <= ev_valid;
      parity_err_reg <= parity_err;
      held_reg       <= held_next;
      if (ev_valid) begin
        key_code_reg <= ReadVal;
        key_ext_reg  <= ev_ext;
        key_rel_reg  <= ev_rel;
      end
    end
  end

  assign KeyValid    = key_valid_reg;
  assign KeyCode     = key_code_reg;
  assign KeyExtended = key_ext_reg;
  assign KeyRelease  = key_rel_reg;
  assign KeyLeft     = held_reg[0];
  assign KeyRight    = held_reg[1];
  assign KeyFire     = held_reg[2];
  assign ParityError = parity_err_reg;

endmodule
